// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    // Requester index; also the encoding of last_grant and read ownership.
    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_idx_e;

    // Width of the optional statistics counters.
    localparam int CNT_W = 16;

    // Deepest read latency the return pipeline supports.
    localparam int RD_LATENCY_MAX = 4;

    // Saturating increment: counts up when en is set, sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             en);
        if (en && (value != {CNT_W{1'b1}})) begin
            return value + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/mem_arb_rd_pipe.sv
// Read-return tracker: a RD_LATENCY-deep valid/owner shift pipeline.
// An issued read emerges at rd_valid exactly RD_LATENCY cycles later,
// tagged with the requester that issued it. Out-of-range latencies are
// clamped to 1..RD_LATENCY_MAX.
module mem_arb_rd_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     issue_valid,
    input  req_idx_e issue_owner,
    output logic     rd_valid,
    output req_idx_e rd_owner
);

    localparam int DEPTH = (RD_LATENCY < 1) ? 1 :
                           ((RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY);

    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] owner_r;

    // Advance every in-flight read one stage per cycle; reset drops them all.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_r <= '0;
            owner_r <= '0;
        end else begin
            valid_r[0] <= issue_valid;
            owner_r[0] <= issue_owner;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                owner_r[i] <= owner_r[i-1];
            end
        end
    end

    assign rd_valid = valid_r[DEPTH-1];
    assign rd_owner = req_idx_e'(owner_r[DEPTH-1]);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Arbitration is combinational within the cycle with round-robin on
// contention; read data returns RD_LATENCY cycles after the grant and is
// steered to its owner by the read-return pipeline.
// Optional feature: define MEM_ARB_STATS_EN to add saturating grant and
// conflict counters (grant_cnt0, grant_cnt1, conflict_cnt).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_clken,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    input  logic [DATA_W-1:0]   mem_readdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]    grant_cnt0,
    output logic [CNT_W-1:0]    grant_cnt1,
    output logic [CNT_W-1:0]    conflict_cnt
`endif
);

    logic     m0_active_s;
    logic     m1_active_s;
    logic     both_active_s;
    logic     grant_valid_s;
    req_idx_e grant_idx_s;
    logic     grant_write_s;
    logic     rd_issue_s;
    req_idx_e last_grant_r;
    logic     rd_valid_s;
    req_idx_e rd_owner_s;

    assign m0_active_s   = m0_read | m0_write;
    assign m1_active_s   = m1_read | m1_write;
    assign both_active_s = m0_active_s & m1_active_s;
    assign rd_issue_s    = grant_valid_s & ~grant_write_s;

    // Choose this cycle's winner: a lone requester wins, contention goes to
    // the requester that did not win last time. Write dominates read.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = REQ_M0;
        grant_write_s = 1'b0;
        if (!reset_n) begin
            grant_valid_s = 1'b0;
        end else if (both_active_s) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = (last_grant_r == REQ_M0) ? REQ_M1 : REQ_M0;
        end else if (m0_active_s) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = REQ_M0;
        end else if (m1_active_s) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = REQ_M1;
        end else begin
            grant_valid_s = 1'b0;
        end
        grant_write_s = (grant_idx_s == REQ_M1) ? m1_write : m0_write;
    end

    // Remember the most recent winner; reset favours requester 0 next.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_r <= REQ_M1;
        end else if (grant_valid_s) begin
            last_grant_r <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Put the winner on the RAM port and answer both requester handshakes.
    always_comb begin
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_clken      = reset_n;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        if (reset_n) begin
            m0_waitrequest = m0_active_s & ~(grant_valid_s & (grant_idx_s == REQ_M0));
            m1_waitrequest = m1_active_s & ~(grant_valid_s & (grant_idx_s == REQ_M1));
            if (grant_valid_s) begin
                mem_chipselect = 1'b1;
                mem_write      = grant_write_s;
                case (grant_idx_s)
                    REQ_M0: begin
                        mem_address    = m0_address;
                        mem_writedata  = m0_writedata;
                        mem_byteenable = m0_byteenable;
                    end
                    REQ_M1: begin
                        mem_address    = m1_address;
                        mem_writedata  = m1_writedata;
                        mem_byteenable = m1_byteenable;
                    end
                    default: begin
                        mem_chipselect = 1'b0;
                        mem_write      = 1'b0;
                    end
                endcase
            end else begin
                mem_chipselect = 1'b0;
                mem_write      = 1'b0;
            end
        end else begin
            m0_waitrequest = 1'b1;
            m1_waitrequest = 1'b1;
        end
    end

    mem_arb_rd_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (rd_issue_s),
        .issue_owner (grant_idx_s),
        .rd_valid    (rd_valid_s),
        .rd_owner    (rd_owner_s)
    );

    // Both requesters see the RAM data; only the owner gets the valid pulse.
    always_comb begin
        m0_readdata      = '0;
        m1_readdata      = '0;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;
        if (reset_n) begin
            m0_readdata      = mem_readdata;
            m1_readdata      = mem_readdata;
            m0_readdatavalid = rd_valid_s & (rd_owner_s == REQ_M0);
            m1_readdatavalid = rd_valid_s & (rd_owner_s == REQ_M1);
        end else begin
            m0_readdatavalid = 1'b0;
            m1_readdatavalid = 1'b0;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt0_r;
    logic [CNT_W-1:0] grant_cnt1_r;
    logic [CNT_W-1:0] conflict_cnt_r;

    // Saturating counts of grants per requester and of contended cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_cnt0_r   <= '0;
            grant_cnt1_r   <= '0;
            conflict_cnt_r <= '0;
        end else begin
            grant_cnt0_r   <= sat_inc(grant_cnt0_r, grant_valid_s & (grant_idx_s == REQ_M0));
            grant_cnt1_r   <= sat_inc(grant_cnt1_r, grant_valid_s & (grant_idx_s == REQ_M1));
            conflict_cnt_r <= sat_inc(conflict_cnt_r, both_active_s);
        end
    end

    assign grant_cnt0   = reset_n ? grant_cnt0_r   : '0;
    assign grant_cnt1   = reset_n ? grant_cnt1_r   : '0;
    assign conflict_cnt = reset_n ? conflict_cnt_r : '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Instance A (RD_LATENCY=1)
// carries the functional scenarios against a byte-enabled RAM model; instance
// B (RD_LATENCY=2) covers a read killed by reset. Read returns of A are
// checked by a scoreboard fed when each read is issued.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Free-running cycle number used for return-latency expectations.
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A signals ----------------
    logic              rst_a_n;
    logic              m0_read_a, m0_write_a, m1_read_a, m1_write_a;
    logic [ADDR_W-1:0] m0_address_a, m1_address_a;
    logic [DATA_W-1:0] m0_writedata_a, m1_writedata_a;
    logic [BE_W-1:0]   m0_byteenable_a, m1_byteenable_a;
    logic              m0_waitrequest_a, m1_waitrequest_a;
    logic [DATA_W-1:0] m0_readdata_a, m1_readdata_a;
    logic              m0_readdatavalid_a, m1_readdatavalid_a;
    logic [ADDR_W-1:0] mem_address_a;
    logic              mem_chipselect_a, mem_clken_a, mem_write_a;
    logic [DATA_W-1:0] mem_writedata_a, mem_readdata_a;
    logic [BE_W-1:0]   mem_byteenable_a;

    // ---------------- instance B signals ----------------
    logic              rst_b_n;
    logic              m0_read_b, m0_write_b, m1_read_b, m1_write_b;
    logic [ADDR_W-1:0] m0_address_b, m1_address_b;
    logic [DATA_W-1:0] m0_writedata_b, m1_writedata_b;
    logic [BE_W-1:0]   m0_byteenable_b, m1_byteenable_b;
    logic              m0_waitrequest_b, m1_waitrequest_b;
    logic [DATA_W-1:0] m0_readdata_b, m1_readdata_b;
    logic              m0_readdatavalid_b, m1_readdatavalid_b;
    logic [ADDR_W-1:0] mem_address_b;
    logic              mem_chipselect_b, mem_clken_b, mem_write_b;
    logic [DATA_W-1:0] mem_writedata_b, mem_readdata_b, mem_readdata_b1;
    logic [BE_W-1:0]   mem_byteenable_b;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] grant_cnt0_a, grant_cnt1_a, conflict_cnt_a;
    logic [15:0] grant_cnt0_b, grant_cnt1_b, conflict_cnt_b;
`endif

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(1)) dut_a (
        .clk(clk), .reset_n(rst_a_n),
        .m0_read(m0_read_a), .m0_write(m0_write_a), .m0_address(m0_address_a),
        .m0_writedata(m0_writedata_a), .m0_byteenable(m0_byteenable_a),
        .m0_waitrequest(m0_waitrequest_a), .m0_readdata(m0_readdata_a),
        .m0_readdatavalid(m0_readdatavalid_a),
        .m1_read(m1_read_a), .m1_write(m1_write_a), .m1_address(m1_address_a),
        .m1_writedata(m1_writedata_a), .m1_byteenable(m1_byteenable_a),
        .m1_waitrequest(m1_waitrequest_a), .m1_readdata(m1_readdata_a),
        .m1_readdatavalid(m1_readdatavalid_a),
        .mem_address(mem_address_a), .mem_chipselect(mem_chipselect_a),
        .mem_clken(mem_clken_a), .mem_write(mem_write_a),
        .mem_writedata(mem_writedata_a), .mem_byteenable(mem_byteenable_a),
        .mem_readdata(mem_readdata_a)
`ifdef MEM_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0_a), .grant_cnt1(grant_cnt1_a), .conflict_cnt(conflict_cnt_a)
`endif
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(2)) dut_b (
        .clk(clk), .reset_n(rst_b_n),
        .m0_read(m0_read_b), .m0_write(m0_write_b), .m0_address(m0_address_b),
        .m0_writedata(m0_writedata_b), .m0_byteenable(m0_byteenable_b),
        .m0_waitrequest(m0_waitrequest_b), .m0_readdata(m0_readdata_b),
        .m0_readdatavalid(m0_readdatavalid_b),
        .m1_read(m1_read_b), .m1_write(m1_write_b), .m1_address(m1_address_b),
        .m1_writedata(m1_writedata_b), .m1_byteenable(m1_byteenable_b),
        .m1_waitrequest(m1_waitrequest_b), .m1_readdata(m1_readdata_b),
        .m1_readdatavalid(m1_readdatavalid_b),
        .mem_address(mem_address_b), .mem_chipselect(mem_chipselect_b),
        .mem_clken(mem_clken_b), .mem_write(mem_write_b),
        .mem_writedata(mem_writedata_b), .mem_byteenable(mem_byteenable_b),
        .mem_readdata(mem_readdata_b)
`ifdef MEM_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0_b), .grant_cnt1(grant_cnt1_b), .conflict_cnt(conflict_cnt_b)
`endif
    );

    // Background RAM content: a recognisable tag plus the word address.
    function automatic logic [31:0] pat(input int a);
        logic [9:0] a10;
        a10 = a[9:0];
        return {16'hC0DE, 6'd0, a10};
    endfunction

    // RAM model for instance A: byte-enabled write, 1-cycle registered read.
    logic [DATA_W-1:0] ram_a [1024];
    logic ram_a_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_a_ready) begin
            for (int i = 0; i < 1024; i++) ram_a[i] <= pat(i);
            ram_a_ready <= 1'b1;
        end else if (mem_chipselect_a && mem_clken_a && mem_write_a) begin
            for (int b = 0; b < BE_W; b++)
                if (mem_byteenable_a[b]) ram_a[mem_address_a][8*b +: 8] <= mem_writedata_a[8*b +: 8];
        end
        mem_readdata_a <= ram_a[mem_address_a];
    end

    // RAM model for instance B: 2-cycle read returning the address pattern.
    always @(posedge clk) begin
        mem_readdata_b1 <= pat(int'(mem_address_b));
        mem_readdata_b  <= mem_readdata_b1;
    end

    // Scoreboard of expected read returns for instance A.
    typedef struct { int owner; logic [31:0] data; int due; } exp_t;
    exp_t sb_q[$];

    // Match every read return of A against the oldest expected entry.
    always @(negedge clk) begin : sb_mon
        exp_t e;
        int   got_owner;
        logic [31:0] got_data;
        if (rst_a_n === 1'b1) begin
            if (m0_readdatavalid_a || m1_readdatavalid_a) begin
                checks++;
                got_owner = m1_readdatavalid_a ? 1 : 0;
                got_data  = got_owner == 1 ? m1_readdata_a : m0_readdata_a;
                if (m0_readdatavalid_a && m1_readdatavalid_a) begin
                    errors++;
                    $display("FAIL rd_both_valid: both readdatavalid high at cycle %0d, required at most one", cyc);
                end else if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: owner %0d data %h at cycle %0d, required no return", got_owner, got_data, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (got_owner != e.owner || got_data !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL rd_return: got owner %0d data %h cycle %0d, required owner %0d data %h cycle %0d",
                                 got_owner, got_data, cyc, e.owner, e.data, e.due);
                    end
                end
            end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                checks++;
                errors++;
                e = sb_q.pop_front();
                $display("FAIL rd_missing: no return at cycle %0d, required owner %0d data %h", cyc, e.owner, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        m0_read_a = 1'b0; m0_write_a = 1'b0; m1_read_a = 1'b0; m1_write_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        m0_read_a = 1'b1; m1_write_a = 1'b1; m0_address_a = 10'h155; m1_address_a = 10'h2AA;
        m1_writedata_a = 32'hFFFF_FFFF; m1_byteenable_a = 4'hF; m0_read_b = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (m0_waitrequest_a !== 1'b1) begin errors++; $display("FAIL rst_m0_wait: got %b want 1", m0_waitrequest_a); end
        checks++; if (m1_waitrequest_a !== 1'b1) begin errors++; $display("FAIL rst_m1_wait: got %b want 1", m1_waitrequest_a); end
        checks++; if (mem_chipselect_a !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", mem_chipselect_a); end
        checks++; if (mem_write_a !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b want 0", mem_write_a); end
        checks++; if (mem_clken_a !== 1'b0) begin errors++; $display("FAIL rst_clken: got %b want 0", mem_clken_a); end
        checks++; if (mem_address_a !== 10'h000) begin errors++; $display("FAIL rst_addr: got %h want 000", mem_address_a); end
        checks++; if (mem_writedata_a !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", mem_writedata_a); end
        checks++; if (m0_readdata_a !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", m0_readdata_a); end
        checks++; if (m0_readdatavalid_a !== 1'b0) begin errors++; $display("FAIL rst_rdv: got %b want 0", m0_readdatavalid_a); end
        checks++; if (m0_waitrequest_b !== 1'b1) begin errors++; $display("FAIL rst_b_wait: got %b want 1", m0_waitrequest_b); end
        tick();
        idle_a(); m0_read_b = 1'b0; rst_a_n = 1'b1; rst_b_n = 1'b1;
        @(negedge clk);
        checks++; if (mem_clken_a !== 1'b1) begin errors++; $display("FAIL run_clken: got %b want 1", mem_clken_a); end
        checks++; if (m0_waitrequest_a !== 1'b0) begin errors++; $display("FAIL idle_m0_wait: got %b want 0", m0_waitrequest_a); end
        checks++; if (mem_chipselect_a !== 1'b0) begin errors++; $display("FAIL idle_cs: got %b want 0", mem_chipselect_a); end
    endtask

    task automatic test_single_requester();
        tick();
        m0_write_a = 1'b1; m0_address_a = 10'h3FF; m0_writedata_a = 32'hDEADBEEF; m0_byteenable_a = 4'hF;
        @(negedge clk);
        checks++; if (m0_waitrequest_a !== 1'b0) begin errors++; $display("FAIL single_wr_wait: got %b want 0", m0_waitrequest_a); end
        checks++; if ({mem_chipselect_a, mem_write_a} !== 2'b11) begin errors++; $display("FAIL single_wr_cs_wr: got %b want 11", {mem_chipselect_a, mem_write_a}); end
        checks++; if (mem_address_a !== 10'h3FF) begin errors++; $display("FAIL single_wr_addr: got %h want 3ff", mem_address_a); end
        checks++; if (mem_writedata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wr_data: got %h want deadbeef", mem_writedata_a); end
        checks++; if (m1_waitrequest_a !== 1'b0) begin errors++; $display("FAIL single_idle_m1_wait: got %b want 0", m1_waitrequest_a); end
        tick();
        m0_write_a = 1'b0; m0_read_a = 1'b1;
        sb_q.push_back('{0, 32'hDEADBEEF, cyc + 1});
        @(negedge clk);
        checks++; if (m0_waitrequest_a !== 1'b0) begin errors++; $display("FAIL single_rd_wait: got %b want 0", m0_waitrequest_a); end
        checks++; if (mem_write_a !== 1'b0) begin errors++; $display("FAIL single_rd_wr: got %b want 0", mem_write_a); end
        tick();
        idle_a();
        @(negedge clk);
        checks++; if (m0_readdatavalid_a !== 1'b1 || m0_readdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rd_return: got rdv %b data %h want 1 deadbeef", m0_readdatavalid_a, m0_readdata_a); end
        tick();
        @(negedge clk);
        checks++; if (m0_readdatavalid_a !== 1'b0) begin errors++; $display("FAIL single_rdv_pulse: got %b want 0", m0_readdatavalid_a); end
    endtask

    task automatic test_byte_write();
        tick();
        m1_write_a = 1'b1; m1_address_a = 10'h005; m1_writedata_a = 32'h11223344; m1_byteenable_a = 4'hF;
        tick();
        m1_writedata_a = 32'hAABBCCDD; m1_byteenable_a = 4'h5;
        @(negedge clk);
        checks++; if (mem_byteenable_a !== 4'h5) begin errors++; $display("FAIL byte_be: got %h want 5", mem_byteenable_a); end
        checks++; if (m1_waitrequest_a !== 1'b0) begin errors++; $display("FAIL byte_m1_wait: got %b want 0", m1_waitrequest_a); end
        tick();
        m1_write_a = 1'b0; m1_read_a = 1'b1;
        sb_q.push_back('{1, 32'h11BB33DD, cyc + 1});
        tick();
        idle_a();
        repeat (2) tick();
    endtask

    task automatic test_read_write();
        tick();
        m0_read_a = 1'b1; m0_write_a = 1'b1; m0_address_a = 10'h077; m0_writedata_a = 32'h12345678; m0_byteenable_a = 4'hF;
        @(negedge clk);
        checks++; if (mem_write_a !== 1'b1) begin errors++; $display("FAIL rw_mem_write: got %b want 1", mem_write_a); end
        checks++; if (m0_waitrequest_a !== 1'b0) begin errors++; $display("FAIL rw_wait: got %b want 0", m0_waitrequest_a); end
        tick();
        idle_a();
        @(negedge clk);
        checks++; if (m0_readdatavalid_a !== 1'b0) begin errors++; $display("FAIL rw_no_rdv: got %b want 0", m0_readdatavalid_a); end
        tick();
        m0_read_a = 1'b1;
        sb_q.push_back('{0, 32'h12345678, cyc + 1});
        tick();
        idle_a();
        repeat (2) tick();
    endtask

    task automatic test_round_robin();
        tick();
        m1_read_a = 1'b1; m1_address_a = 10'h0A1;
        sb_q.push_back('{1, pat(32'h0A1), cyc + 1});
        tick();
        m0_read_a = 1'b1; m0_address_a = 10'h0B0; m1_address_a = 10'h0B1;
        sb_q.push_back('{0, pat(32'h0B0), cyc + 1});
        @(negedge clk);
        checks++; if ({m0_waitrequest_a, m1_waitrequest_a} !== 2'b01) begin errors++; $display("FAIL rr_after_m1: got waits %b want 01", {m0_waitrequest_a, m1_waitrequest_a}); end
        checks++; if (mem_address_a !== 10'h0B0) begin errors++; $display("FAIL rr_after_m1_addr: got %h want 0b0", mem_address_a); end
        tick();
        m1_read_a = 1'b0; m0_address_a = 10'h0C0;
        sb_q.push_back('{0, pat(32'h0C0), cyc + 1});
        tick();
        m1_read_a = 1'b1; m1_address_a = 10'h0C1;
        sb_q.push_back('{1, pat(32'h0C1), cyc + 1});
        @(negedge clk);
        checks++; if ({m0_waitrequest_a, m1_waitrequest_a} !== 2'b10) begin errors++; $display("FAIL rr_after_m0: got waits %b want 10", {m0_waitrequest_a, m1_waitrequest_a}); end
        checks++; if (mem_address_a !== 10'h0C1) begin errors++; $display("FAIL rr_after_m0_addr: got %h want 0c1", mem_address_a); end
        tick();
        idle_a();
        repeat (2) tick();
    endtask

    task automatic test_contention();
        tick();
        rst_a_n = 1'b0;
        tick();
        rst_a_n = 1'b1;
        m0_read_a = 1'b1; m0_address_a = 10'h020;
        m1_read_a = 1'b1; m1_address_a = 10'h040;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            sb_q.push_back('{k % 2, (k % 2 == 0) ? pat(32'h020) : pat(32'h040), cyc + 1});
            @(negedge clk);
            checks++;
            if (m0_waitrequest_a !== ((k % 2) == 1) || m1_waitrequest_a !== ((k % 2) == 0) ||
                mem_address_a !== ((k % 2 == 0) ? 10'h020 : 10'h040)) begin
                errors++;
                $display("FAIL contend_grant_%0d: got waits %b%b addr %h, want owner m%0d", k,
                         m0_waitrequest_a, m1_waitrequest_a, mem_address_a, k % 2);
            end
            if (k > 0) begin
                checks++;
                if (m0_readdatavalid_a !== ((k - 1) % 2 == 0) || m1_readdatavalid_a !== ((k - 1) % 2 == 1)) begin
                    errors++;
                    $display("FAIL contend_rdv_%0d: got rdv %b%b want owner m%0d", k,
                             m0_readdatavalid_a, m1_readdatavalid_a, (k - 1) % 2);
                end
            end
        end
        tick();
        idle_a();
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_read();
        tick();
        m0_read_b = 1'b1; m0_address_b = 10'h010;
        @(negedge clk);
        checks++; if (m0_waitrequest_b !== 1'b0) begin errors++; $display("FAIL midrst_grant: got %b want 0", m0_waitrequest_b); end
        tick();
        m0_read_b = 1'b0; rst_b_n = 1'b0;
        tick();
        rst_b_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (m0_readdatavalid_b !== 1'b0 || m1_readdatavalid_b !== 1'b0) begin
                errors++;
                $display("FAIL midrst_rdv_%0d: got %b%b want 00", k, m0_readdatavalid_b, m1_readdatavalid_b);
            end
            tick();
        end
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        tick();
        rst_a_n = 1'b0;
        tick();
        rst_a_n = 1'b1;
        checks++; if (conflict_cnt_a !== 16'h0000) begin errors++; $display("FAIL stats_reset: got %h want 0000", conflict_cnt_a); end
        m0_write_a = 1'b1; m0_address_a = 10'h100; m1_write_a = 1'b1; m1_address_a = 10'h101;
        for (int k = 1; k <= 70000; k++) begin
            tick();
            if (k == 65534) begin
                checks++; if (conflict_cnt_a !== 16'hFFFE) begin errors++; $display("FAIL stats_conflict_pre: got %h want fffe", conflict_cnt_a); end
            end
        end
        idle_a();
        tick();
        checks++; if (conflict_cnt_a !== 16'hFFFF) begin errors++; $display("FAIL stats_conflict_sat: got %h want ffff", conflict_cnt_a); end
        checks++; if (grant_cnt0_a !== 16'd35000) begin errors++; $display("FAIL stats_grant0: got %0d want 35000", grant_cnt0_a); end
        checks++; if (grant_cnt1_a !== 16'd35000) begin errors++; $display("FAIL stats_grant1: got %0d want 35000", grant_cnt1_a); end
    endtask
`endif

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        m0_read_a = 1'b0; m0_write_a = 1'b0; m1_read_a = 1'b0; m1_write_a = 1'b0;
        m0_address_a = '0; m1_address_a = '0; m0_writedata_a = '0; m1_writedata_a = '0;
        m0_byteenable_a = 4'hF; m1_byteenable_a = 4'hF;
        m0_read_b = 1'b0; m0_write_b = 1'b0; m1_read_b = 1'b0; m1_write_b = 1'b0;
        m0_address_b = '0; m1_address_b = '0; m0_writedata_b = '0; m1_writedata_b = '0;
        m0_byteenable_b = 4'hF; m1_byteenable_b = 4'hF;

        test_reset();
        test_single_requester();
        test_byte_write();
        test_read_write();
        test_round_robin();
        test_contention();
        test_reset_mid_read();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        repeat (4) tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d outstanding reads, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
